change_dispenser: RTL and testbench

- Parametrised successor to the change calculator in the bar-code checkout path.
- Takes a settle request from the main state machine with either a refund or a charge, and computes the change.
- Breaks the change greedily into coins of three denominations.
- Issues one coin per valid/ready handshake to the coin ejector, then reports completion with an explicit status.
- A zero result is reported as status, not as a sentinel value.

---
 rtl/change_dispenser_pkg.sv | 24 ++
 rtl/change_dispenser_coin_picker.sv | 36 +++
 rtl/change_dispenser.sv | 155 +++++++++++++++
 tb/tb_change_dispenser.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared encodings for the change dispenser: FSM states, coin selects and
// completion status codes.
package change_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CALC     = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_LO  = 2'd0,
    SEL_MID = 2'd1,
    SEL_HI  = 2'd2
  } coin_sel_t;

  typedef enum logic [1:0] {
    STATUS_PAID  = 2'd0,
    STATUS_EXACT = 2'd1,
    STATUS_SHORT = 2'd2
  } status_t;

endpackage

// File: rtl/change_dispenser_coin_picker.sv
// Greedy coin selection: picks the largest denomination not exceeding the
// outstanding amount. Purely combinational.
module coin_picker
  import change_pkg::*;
#(
  parameter int MONEY_W  = 5,
  parameter int COIN_HI  = 10,
  parameter int COIN_MID = 5,
  parameter int COIN_LO  = 1
) (
  input  logic [MONEY_W-1:0] remaining,
  output coin_sel_t          coin_sel,
  output logic [MONEY_W-1:0] coin_value
);

  localparam logic [MONEY_W-1:0] HI_V  = MONEY_W'(COIN_HI);
  localparam logic [MONEY_W-1:0] MID_V = MONEY_W'(COIN_MID);
  localparam logic [MONEY_W-1:0] LO_V  = MONEY_W'(COIN_LO);

  // largest-first denomination choice
  always_comb begin
    coin_sel   = SEL_LO;
    coin_value = LO_V;
    if (remaining >= HI_V) begin
      coin_sel   = SEL_HI;
      coin_value = HI_V;
    end else if (remaining >= MID_V) begin
      coin_sel   = SEL_MID;
      coin_value = MID_V;
    end else begin
      coin_sel   = SEL_LO;
      coin_value = LO_V;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Settle-request change dispenser: computes change, pays it greedily one coin
// per valid/ready handshake. Optional per-coin counters: CHANGE_DISPENSER_COIN_COUNT_EN.
module change_dispenser
  import change_pkg::*;
#(
  parameter int MONEY_W  = 5,
  parameter int COIN_HI  = 10,
  parameter int COIN_MID = 5,
  parameter int COIN_LO  = 1,
  parameter int COUNT_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [MONEY_W-1:0] input_money,
  input  logic [MONEY_W-1:0] value_to_pay,
  input  logic               coin_ready,
  output logic               coin_valid,
  output logic [1:0]         coin_sel,
  output logic [MONEY_W-1:0] change_total,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
  ,
  output logic [COUNT_W-1:0] count_hi,
  output logic [COUNT_W-1:0] count_mid,
  output logic [COUNT_W-1:0] count_lo
`endif
);

  state_t             state, next_state;
  logic               mode_q;
  logic [MONEY_W-1:0] money_q, price_q, remaining;
  logic [MONEY_W-1:0] calc_total, pick_value;
  status_t            calc_status, status_q;
  coin_sel_t          pick_sel;
  logic               accept, take;

  assign accept     = (state == ST_IDLE) && start;
  assign coin_valid = (state == ST_DISPENSE);
  assign take       = coin_valid && coin_ready;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign status     = status_q;
  assign coin_sel   = coin_valid ? pick_sel : SEL_LO;

  coin_picker #(
    .MONEY_W  (MONEY_W),
    .COIN_HI  (COIN_HI),
    .COIN_MID (COIN_MID),
    .COIN_LO  (COIN_LO)
  ) u_picker (
    .remaining  (remaining),
    .coin_sel   (pick_sel),
    .coin_value (pick_value)
  );

  // settle amount and outcome from the latched request
  always_comb begin
    calc_total  = money_q;
    calc_status = STATUS_PAID;
    if (mode_q) begin
      if (money_q < price_q) begin
        calc_total  = money_q;
        calc_status = STATUS_SHORT;
      end else if (money_q == price_q) begin
        calc_total  = '0;
        calc_status = STATUS_EXACT;
      end else begin
        calc_total  = money_q - price_q;
        calc_status = STATUS_PAID;
      end
    end else begin
      calc_total  = money_q;
      calc_status = STATUS_PAID;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     next_state = start ? ST_CALC : ST_IDLE;
      ST_CALC:     next_state = (calc_total != '0) ? ST_DISPENSE : ST_DONE;
      ST_DISPENSE: next_state = (take && (remaining == pick_value)) ? ST_DONE : ST_DISPENSE;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // request latch, result registers and outstanding amount
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q       <= 1'b0;
      money_q      <= '0;
      price_q      <= '0;
      remaining    <= '0;
      change_total <= '0;
      status_q     <= STATUS_PAID;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            money_q <= input_money;
            price_q <= value_to_pay;
          end
        end
        ST_CALC: begin
          change_total <= calc_total;
          remaining    <= calc_total;
          status_q     <= calc_status;
        end
        ST_DISPENSE: begin
          if (coin_ready) remaining <= remaining - pick_value;
        end
        default: ;
      endcase
    end
  end

`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // per-denomination coin counters, saturating
  always_ff @(posedge clock) begin
    if (!reset || accept) begin
      count_hi  <= '0;
      count_mid <= '0;
      count_lo  <= '0;
    end else if (take) begin
      case (pick_sel)
        SEL_HI:  count_hi  <= sat_inc(count_hi);
        SEL_MID: count_mid <= sat_inc(count_mid);
        SEL_LO:  count_lo  <= sat_inc(count_lo);
        default: ;
      endcase
    end
  end
`else
  logic [COUNT_W-1:0] count_unused;
  assign count_unused = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised self-checking bench for change_dispenser against a greedy
// arithmetic reference model.
module tb_change_dispenser;

  localparam int MW  = 5;
  localparam int HI  = 10;
  localparam int MID = 5;
  localparam int LO  = 1;
  localparam int CW  = 4;

  logic          clock = 1'b0;
  logic          reset, start, mode, coin_ready;
  logic [MW-1:0] input_money, value_to_pay, change_total;
  logic          coin_valid, busy, done;
  logic [1:0]    coin_sel, status;
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
  logic [CW-1:0] count_hi, count_mid, count_lo;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  change_dispenser #(
    .MONEY_W(MW), .COIN_HI(HI), .COIN_MID(MID), .COIN_LO(LO), .COUNT_W(CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .input_money  (input_money),
    .value_to_pay (value_to_pay),
    .coin_ready   (coin_ready),
    .coin_valid   (coin_valid),
    .coin_sel     (coin_sel),
    .change_total (change_total),
    .busy         (busy),
    .done         (done),
    .status       (status)
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
    ,
    .count_hi     (count_hi),
    .count_mid    (count_mid),
    .count_lo     (count_lo)
`endif
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
  endfunction

  // One settle request; stall holds coin_ready low for that many offered cycles first.
  task automatic run_txn(input bit m, input int money, input int price,
                         input int pct, input int stall);
    int chg, st, nh, nm, nl, r, exp_lat, cyc;
    int q[$];
    bit got_done, full;
    if (!m)                  begin chg = money;         st = 0; end
    else if (money < price)  begin chg = money;         st = 2; end
    else if (money == price) begin chg = 0;             st = 1; end
    else                     begin chg = money - price; st = 0; end
    nh = chg / HI;
    r  = chg % HI;
    nm = r / MID;
    nl = (r % MID) / LO;
    for (int i = 0; i < nh; i++) q.push_back(2);
    for (int i = 0; i < nm; i++) q.push_back(1);
    for (int i = 0; i < nl; i++) q.push_back(0);
    exp_lat  = (chg == 0) ? 2 : nh + nm + nl + 2;
    full     = (pct >= 100) && (stall == 0);
    got_done = 1'b0;

    @(negedge clock);
    mode         = m;
    input_money  = MW'(money);
    value_to_pay = MW'(price);
    coin_ready   = 1'b0;
    start        = 1'b1;

    for (cyc = 1; cyc <= 300 && !got_done; cyc++) begin
      @(negedge clock);
      #1;
      start = 1'b0;
      if (cyc == 1) begin
        check_val("calc_busy", int'(busy), 1);
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
        check_val("cnt_clear", int'(count_hi) + int'(count_mid) + int'(count_lo), 0);
`endif
      end
      if (done) begin
        got_done = 1'b1;
        check_val("status", int'(status), st);
        check_val("change_total", int'(change_total), chg);
        check_val("coins_left", q.size(), 0);
        check_val("done_valid", int'(coin_valid), 0);
        check_val("done_busy", int'(busy), 1);
        if (full) check_val("latency", cyc, exp_lat);
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
        check_val("count_hi", int'(count_hi), sat(nh));
        check_val("count_mid", int'(count_mid), sat(nm));
        check_val("count_lo", int'(count_lo), sat(nl));
`endif
      end else begin
        check_val("coin_valid", int'(coin_valid), (cyc >= 2 && q.size() > 0) ? 1 : 0);
        if (coin_valid && q.size() > 0) check_val("coin_sel", int'(coin_sel), q[0]);
        if (stall > 0 && coin_valid) begin
          coin_ready = 1'b0;
          stall--;
        end else begin
          coin_ready = ($urandom_range(1, 100) <= pct);
        end
        if (coin_valid && coin_ready && q.size() > 0) void'(q.pop_front());
        if ($urandom_range(0, 3) == 0) begin
          start        = 1'b1;
          mode         = 1'($urandom);
          input_money  = MW'($urandom);
          value_to_pay = MW'($urandom);
        end
      end
    end
    if (!got_done) check_val("timeout", 0, 1);
    @(negedge clock);
    #1;
    check_val("idle_busy", int'(busy), 0);
    check_val("idle_done", int'(done), 0);
    check_val("idle_status", int'(status), st);
  endtask

  task automatic reset_mid_dispense();
    @(negedge clock);
    mode = 1'b0; input_money = MW'(7); value_to_pay = '0;
    coin_ready = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #1;
    check_val("pre_rst_valid", int'(coin_valid), 1);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(coin_valid), 0);
    check_val("rst_total", int'(change_total), 0);
    check_val("rst_status", int'(status), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_sel", int'(coin_sel), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; coin_ready = 1'b0;
    input_money = '0; value_to_pay = '0;
    repeat (2) @(negedge clock);
    #1;
    check_val("init_busy", int'(busy), 0);
    check_val("init_valid", int'(coin_valid), 0);
    check_val("init_done", int'(done), 0);
    check_val("init_total", int'(change_total), 0);
    check_val("init_status", int'(status), 0);
    reset = 1'b1;

    run_txn(1'b1, 23, 5, 100, 0);
    run_txn(1'b1, 12, 12, 100, 0);
    run_txn(1'b1, 4, 9, 100, 0);
    run_txn(1'b0, 16, 0, 100, 3);
    run_txn(1'b1, 31, 0, 100, 0);
    run_txn(1'b0, 0, 0, 100, 0);
    run_txn(1'b1, 31, 31, 100, 0);
    reset_mid_dispense();
    run_txn(1'b1, 30, 1, 100, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              (i % 3 == 0) ? 100 : int'($urandom_range(30, 100)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
